// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/subtract: one narrow adder and shifter are
// reused across the align, add and normalize states. Rounding truncates and denormals flush to zero.
module fp_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic        sx, diff_sign;
  logic [7:0]  ex, d;
  logic [23:0] mx, my;
  logic [24:0] sum;

  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        sb_eff, a_big;

  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign ma     = (ea != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
  assign mb     = (eb != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
  assign sb_eff = b[31] ^ sub;
  // Larger magnitude goes to X so the mantissa difference is never negative.
  assign a_big  = {ea, ma} >= {eb, mb};

  logic        norm_done, norm_zero, norm_ovf;
  logic [8:0]  e_final;
  logic [22:0] frac;
  logic [31:0] norm_result;

  always_comb begin
    norm_done   = 1'b0;
    norm_zero   = 1'b0;
    norm_ovf    = 1'b0;
    e_final     = {1'b0, ex};
    frac        = sum[22:0];
    norm_result = 32'd0;
    if (sum[24]) begin
      norm_done = 1'b1;
      e_final   = {1'b0, ex} + 9'd1;
      frac      = sum[23:1];
    end else if (sum == 25'd0) begin
      norm_done = 1'b1;
      norm_zero = 1'b1;
    end else if (sum[23]) begin
      norm_done = 1'b1;
    end else if (ex == 8'd1) begin
      norm_done = 1'b1;
      norm_zero = 1'b1;
    end
    if (!norm_zero) begin
      if (e_final >= 9'd255) begin
        norm_result = {sx, 8'hFF, 23'd0};
        norm_ovf    = 1'b1;
      end else begin
        norm_result = {sx, e_final[7:0], frac};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ALIGN;
      ALIGN:   if (d <= 8'd1 || d > 8'd24) state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx        <= 1'b0;
      diff_sign <= 1'b0;
      ex        <= 8'd0;
      d         <= 8'd0;
      mx        <= 24'd0;
      my        <= 24'd0;
      sum       <= 25'd0;
      result    <= 32'd0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          diff_sign <= a[31] ^ sb_eff;
          if (a_big) begin
            sx <= a[31];  ex <= ea;  mx <= ma;  my <= mb;  d <= ea - eb;
          end else begin
            sx <= sb_eff; ex <= eb;  mx <= mb;  my <= ma;  d <= eb - ea;
          end
        end
        ALIGN: begin
          if (d > 8'd24) begin
            my <= 24'd0;
            d  <= 8'd0;
          end else if (d != 8'd0) begin
            my <= my >> 1;
            d  <= d - 8'd1;
          end
        end
        ADD: sum <= diff_sign ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        NORM: begin
          if (norm_done) begin
            result   <= norm_result;
            overflow <= norm_ovf;
          end else begin
            sum <= {sum[23:0], 1'b0};
            ex  <= ex - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed vector table, randomized operands against
// an arithmetic reference model, and hand-written busy/reset sequences.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, sub;
  logic [31:0] a, b, result;
  logic        busy, done, overflow;

  int check_cnt = 0;
  int pass_cnt  = 0;

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } ref_t;

  // Reference: magnitudes as plain integers, truncating alignment, then
  // normalization by leading-one position with flush when exponent would reach 0.
  function automatic ref_t refModel(input logic [31:0] ta, input logic [31:0] tb_b, input logic tsub);
    ref_t        r;
    int          ea, eb, ex, ey, dd, p, k, e_fin, align, ncyc;
    logic [63:0] ma, mb, mx, my, s, key_a, key_b;
    logic        sa, sbe, sx, sy;
    logic [22:0] fr;
    ea  = int'(ta[30:23]);
    eb  = int'(tb_b[30:23]);
    ma  = (ea != 0) ? (64'h800000 | 64'(ta[22:0])) : 64'd0;
    mb  = (eb != 0) ? (64'h800000 | 64'(tb_b[22:0])) : 64'd0;
    sa  = ta[31];
    sbe = tb_b[31] ^ tsub;
    key_a = 64'(ea) * 64'd16777216 + ma;
    key_b = 64'(eb) * 64'd16777216 + mb;
    if (key_a >= key_b) begin
      ex = ea; ey = eb; mx = ma; my = mb; sx = sa; sy = sbe;
    end else begin
      ex = eb; ey = ea; mx = mb; my = ma; sx = sbe; sy = sa;
    end
    dd    = ex - ey;
    align = (dd == 0 || dd > 24) ? 1 : dd;
    if (dd > 24) my = 64'd0;
    else         my = my >> dd;
    s = (sx == sy) ? (mx + my) : (mx - my);
    r.res = 32'd0;
    r.ovf = 1'b0;
    e_fin = 0;
    fr    = 23'd0;
    ncyc  = 1;
    if (s != 64'd0) begin
      p = 0;
      for (int i = 0; i < 25; i++) if (s[i]) p = i;
      if (p == 24) begin
        e_fin = ex + 1;
        fr    = 23'(s >> 1);
      end else begin
        k = 23 - p;
        if (ex - k >= 1) begin
          e_fin = ex - k;
          fr    = 23'(s << k);
          ncyc  = 1 + k;
        end else begin
          e_fin = -1;
          ncyc  = ex;
        end
      end
      if (e_fin >= 255) begin
        r.res = {sx, 8'hFF, 23'd0};
        r.ovf = 1'b1;
      end else if (e_fin > 0) begin
        r.res = {sx, 8'(e_fin), fr};
      end
    end
    r.lat = align + ncyc + 2;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Issues one operation in the next IDLE cycle and waits (bounded) for done.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_b, input logic tsub,
                               output logic [31:0] res, output logic ovf, output int lat);
    @(posedge clk); #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    a = ta; b = tb_b; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    checkOutput("busy_rise", 32'(busy), 32'd1);
    lat = -1; res = 32'hDEAD_BEEF; ovf = 1'bx;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        lat = k; res = result; ovf = overflow;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  vec_t        vecs[10];
  logic [31:0] res;
  logic        ovf;
  int          lat, ndone;
  ref_t        r;

  initial begin
    vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4};
    vecs[1] = '{32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 1'b0, 5};
    vecs[2] = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 6};
    vecs[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4};
    vecs[4] = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 4};
    vecs[5] = '{32'h3E800000, 32'h3F800000, 1'b1, 32'hBF400000, 1'b0, 6};
    vecs[6] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 4};
    vecs[7] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 4};
    vecs[8] = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 4};
    vecs[9] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 4};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, res, ovf, lat);
      checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d_overflow", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    for (int n = 0; n < 60; n++) begin
      int          ea, eb, mode;
      logic [31:0] ra, rb;
      logic        rs;
      ea   = $urandom_range(1, 254);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       eb = ea;
        1:       eb = ea + $urandom_range(0, 54) - 27;
        2:       eb = $urandom_range(0, 255);
        default: eb = 0;
      endcase
      if (eb < 0)   eb = 0;
      if (eb > 255) eb = 255;
      ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (mode == 0) rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      r  = refModel(ra, rb, rs);
      applyStimulus(ra, rb, rs, res, ovf, lat);
      checkOutput($sformatf("rnd%0d_result", n), res, r.res);
      checkOutput($sformatf("rnd%0d_overflow", n), 32'(ovf), 32'(r.ovf));
      checkOutput($sformatf("rnd%0d_latency", n), 32'(lat), 32'(r.lat));
    end

    // start held high through the whole operation, including the DONE cycle
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; start = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) begin a = 32'h40400000; b = 32'h40400000; end
      if (k == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checkOutput("held_start_done_count", 32'(ndone), 32'd1);
    checkOutput("held_start_result", result, 32'h40000000);

    // asynchronous reset while in NORM discards the operation
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h3F400000; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midnorm_busy", 32'(busy), 32'd0);
    checkOutput("midnorm_done", 32'(done), 32'd0);
    checkOutput("midnorm_result", result, 32'd0);
    checkOutput("midnorm_overflow", 32'(overflow), 32'd0);
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checkOutput("after_reset_no_done", 32'(ndone), 32'd0);

    applyStimulus(32'h3FC00000, 32'h3E800000, 1'b0, res, ovf, lat);
    checkOutput("post_reset_result", res, 32'h3FE00000);
    checkOutput("post_reset_latency", 32'(lat), 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
